// File: rtl/uart_tx_even_parity.sv
// Even-parity UART transmitter: start bit, 8 data bits LSB first, parity, STOP_BITS stop bits; registered outputs.
// The line drops 1 cycle after accept; TX_READY is high only in IDLE, so a producer stalls for the whole frame.
module uart_tx_even_parity #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD,
  parameter int STOP_BITS    = 1
) (
  input  logic       CLK50MHz,
  input  logic       RESET,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX,
  output logic       BUSY,
  output logic       DONE
);

  localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             stop_q, stop_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
  logic             last_stop_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    bit_end     = (cnt_q == CNT_LAST);
    last_stop_d = 1'b1;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (TX_VALID && ready_q) begin
          state_d  = S_START;
          cnt_d    = '0;
          shift_d  = TX_DATA;
          parity_d = ^TX_DATA;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
            state_d = S_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from the next state so they line up with it once registered.
    if (STOP_BITS == 2) begin
      last_stop_d = stop_d;
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[idx_d];
      S_PARITY: tx_d = parity_d;
      default:  tx_d = 1'b1;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && last_stop_d && (cnt_d == CNT_LAST);
  end

  always_ff @(posedge CLK50MHz or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      stop_q   <= 1'b0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign TX       = tx_q;
  assign TX_READY = ready_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_uart_tx_even_parity.sv
// Bench for uart_tx_even_parity: a 1-stop and a 2-stop instance at 16 clocks per bit,
// checked every cycle against a frame-level model plus hand-computed line timings.
module tb_uart_tx_even_parity;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       RESET = 1'b0;
  logic       v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d1 = 8'h00, d2 = 8'h00;
  logic       tx1, rdy1, busy1, done1;
  logic       tx2, rdy2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_even_parity #(.CLK_HZ(160), .BAUD(10), .STOP_BITS(1)) dut1 (
    .CLK50MHz(clk), .RESET(RESET), .TX_DATA(d1), .TX_VALID(v1),
    .TX_READY(rdy1), .TX(tx1), .BUSY(busy1), .DONE(done1)
  );

  uart_tx_even_parity #(.CLK_HZ(160), .BAUD(10), .STOP_BITS(2)) dut2 (
    .CLK50MHz(clk), .RESET(RESET), .TX_DATA(d2), .TX_VALID(v2),
    .TX_READY(rdy2), .TX(tx2), .BUSY(busy2), .DONE(done2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  // Model: a frame is a list of bit values, each held CPB cycles, from the cycle after accept.
  logic       m_act [2] = '{1'b0, 1'b0};
  int         m_el  [2] = '{0, 0};
  logic [11:0] m_bits [2];
  int         m_len [2] = '{11 * CPB, 12 * CPB};

  function automatic logic [11:0] frame_bits(input logic [7:0] b);
    logic [11:0] f;
    int ones;
    ones = 0;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = b[i];
      ones += int'(b[i]);
    end
    f[9] = (ones % 2) == 1;
    return f;
  endfunction

  task automatic model_cycle(input int k, input logic rst, input logic vld,
                             input logic [7:0] dat, input logic [3:0] act);
    logic [3:0] exp;
    if (!rst) begin
      m_act[k] = 1'b0;
      exp = 4'b1100;
    end else if (m_act[k]) begin
      exp = {m_bits[k][m_el[k] / CPB], 1'b0, 1'b1, m_el[k] == m_len[k] - 1};
    end else begin
      exp = 4'b1100;
    end
    chk($sformatf("dut%0d {tx,ready,busy,done} at %0t", k + 1, $time), {28'd0, act}, {28'd0, exp});
    if (rst) begin
      if (m_act[k]) begin
        m_el[k]++;
        if (m_el[k] == m_len[k]) m_act[k] = 1'b0;
      end else if (vld) begin
        m_act[k]  = 1'b1;
        m_el[k]   = 0;
        m_bits[k] = frame_bits(dat);
      end
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, RESET, v1, d1, {tx1, rdy1, busy1, done1});
    model_cycle(1, RESET, v2, d2, {tx2, rdy2, busy2, done2});
  end

  function automatic logic get_tx(input int k);
    return (k == 0) ? tx1 : tx2;
  endfunction

  function automatic logic get_rdy(input int k);
    return (k == 0) ? rdy1 : rdy2;
  endfunction

  // Returns just after the accepting edge; the next falling edge is the first start-bit cycle.
  task automatic send(input int k, input logic [7:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    if (k == 0) begin d1 = b; v1 = 1'b1; end else begin d2 = b; v2 = 1'b1; end
    do begin @(negedge clk); n++; end while (get_rdy(k) !== 1'b1 && n < 1000);
    if (get_rdy(k) !== 1'b1) timeout("send ready");
    @(posedge clk); #1;
    if (k == 0) v1 = 1'b0; else v2 = 1'b0;
  endtask

  task automatic rx(input int k, output logic [7:0] b, output logic par, output logic stp);
    int n;
    b = '0; par = 1'b0; stp = 1'b0; n = 0;
    do begin @(negedge clk); n++; end while (get_tx(k) !== 1'b0 && n < 1000);
    if (get_tx(k) !== 1'b0) begin
      timeout("rx start bit");
      return;
    end
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = get_tx(k);
    end
    repeat (CPB) @(negedge clk);
    par = get_tx(k);
    repeat (CPB) @(negedge clk);
    stp = get_tx(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] samp;
    logic [10:0] exp55;
    logic [7:0]  rb;
    logic        rp, rs;
    logic [7:0]  t3_dat [3];
    logic        t3_par [3];
    int done_cnt, done_at, run, rdyc, hi, busyc, n;
    logic found;

    // 1: reset with TX_VALID held, then a second reset mid-idle.
    d1 = 8'h5A; v1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1 tx in reset", tx1, 1); chk("t1 ready in reset", rdy1, 1);
    chk("t1 busy in reset", busy1, 0); chk("t1 done in reset", done1, 0);
    @(posedge clk); #1; RESET = 1'b1; v1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t1 busy after release", busy1, 0);
    @(posedge clk); #1; RESET = 1'b0; v1 = 1'b1; d1 = 8'h33;
    repeat (4) @(negedge clk);
    chk("t1 tx mid-idle reset", tx1, 1); chk("t1 ready mid-idle reset", rdy1, 1);
    chk("t1 busy mid-idle reset", busy1, 0);
    @(posedge clk); #1; RESET = 1'b1; v1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1 nothing accepted", busy1, 0);

    // 2: 0x55 sampled at bit mid-points; DONE once, 11*CPB cycles after the start edge.
    exp55 = 11'b1_0_01010101_0;
    send(0, 8'h55);
    done_cnt = 0; done_at = 0;
    for (int j = 0; j < 11 * CPB + 8; j++) begin
      @(negedge clk);
      if (j % CPB == CPB / 2 && j / CPB < 11) samp[j / CPB] = tx1;
      if (done1) begin done_cnt++; done_at = j + 1; end
    end
    for (int i = 0; i < 11; i++) chk($sformatf("t2 0x55 bit %0d", i), samp[i], exp55[i]);
    chk("t2 done count", done_cnt, 1);
    chk("t2 done cycle", done_at, 176);

    // 3: parity corners decoded by the bench receiver.
    t3_dat = '{8'h07, 8'h00, 8'hFF};
    t3_par = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send(0, t3_dat[i]);
      rx(0, rb, rp, rs);
      chk($sformatf("t3 byte %0d", i), rb, t3_dat[i]);
      chk($sformatf("t3 parity %0d", i), rp, t3_par[i]);
      chk($sformatf("t3 stop %0d", i), rs, 1);
    end

    // 4: TX_VALID held across two frames.
    @(posedge clk); #1; d1 = 8'hA5; v1 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (rdy1 !== 1'b1 && n < 1000);
    @(posedge clk); #1; d1 = 8'h3C;
    run = 0; rdyc = 0; found = 1'b0;
    for (int j = 0; j < 400; j++) begin
      @(negedge clk);
      if (rdy1) rdyc++;
      if (tx1) run++;
      else begin
        if (j >= 176) begin found = 1'b1; break; end
        run = 0;
      end
    end
    if (!found) timeout("t4 second frame");
    @(posedge clk); #1; v1 = 1'b0;
    chk("t4 idle gap", run, 17);
    chk("t4 ready cycles", rdyc, 1);
    rx(0, rb, rp, rs);
    chk("t4 second byte", rb, 8'h3C);
    chk("t4 second parity", rp, 0);

    // 5: TX_DATA/TX_VALID disturbed mid-frame.
    send(0, 8'hC3);
    fork
      rx(0, rb, rp, rs);
      begin
        repeat (40) @(posedge clk); #1; d1 = 8'hFF; v1 = 1'b1;
        @(negedge clk); chk("t5 ready mid-frame", rdy1, 0);
        @(posedge clk); #1; v1 = 1'b0;
      end
    join
    chk("t5 byte", rb, 8'hC3);
    chk("t5 parity", rp, 0);
    repeat (20) @(negedge clk);
    busyc = 0;
    for (int j = 0; j < 60; j++) begin @(negedge clk); if (busy1) busyc++; end
    chk("t5 no extra frame", busyc, 0);

    // 6: reset during data bit 4 of 0xE5 (bit 4 is 0), then a clean 0x81.
    send(0, 8'hE5);
    repeat (85) @(posedge clk);
    #1; chk("t6 tx low before reset", tx1, 0);
    RESET = 1'b0;
    #1; chk("t6 tx high at once", tx1, 1); chk("t6 busy at once", busy1, 0);
    repeat (3) @(posedge clk); #1; RESET = 1'b1;
    done_cnt = 0;
    for (int j = 0; j < 120; j++) begin @(negedge clk); if (done1) done_cnt++; end
    chk("t6 no done", done_cnt, 0);
    send(0, 8'h81);
    rx(0, rb, rp, rs);
    chk("t6 byte", rb, 8'h81);
    chk("t6 parity", rp, 0);
    chk("t6 stop", rs, 1);

    // 7: two stop bits on the second instance.
    send(1, 8'h12);
    hi = 0; done_cnt = 0; done_at = 0;
    for (int j = 0; j < 12 * CPB + 10; j++) begin
      @(negedge clk);
      if (tx2 && busy2 && j >= 10 * CPB) hi++;
      if (done2) begin done_cnt++; done_at = j + 1; end
    end
    chk("t7 stop high cycles", hi, 32);
    chk("t7 done cycle", done_at, 192);
    chk("t7 done count", done_cnt, 1);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
